// File: rtl/sky130_fd_io__amux_arbiter.sv
// Round-robin arbiter sharing amuxbus_a/amuxbus_b between analog pad requesters.
// Each bus runs its own IDLE/CONNECT/OWNED/BREAK sequencer with registered outputs.
module sky130_fd_io__amux_arbiter #(
    parameter int NREQ          = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int BBM_CYCLES    = 2,
    parameter int MAX_HOLD      = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pwr_good,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] bus_sel,
    output logic [NREQ-1:0] sw_en_a,
    output logic [NREQ-1:0] sw_en_b,
    output logic [NREQ-1:0] gnt
);

    localparam int OW   = $clog2(NREQ);
    localparam int CMAX = (SETTLE_CYCLES > BBM_CYCLES) ? SETTLE_CYCLES : BBM_CYCLES;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
    localparam int HW   = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] BBM_LAST    = CW'(BBM_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_INIT   = (MAX_HOLD == 0) ? HW'(0) : HW'(1);

    typedef enum logic [1:0] {
        IDLE,
        CONNECT,
        OWNED,
        BREAK
    } state_t;

    logic [NREQ-1:0] sw_nx  [2];
    logic [NREQ-1:0] gnt_nx [2];

    for (genvar b = 0; b < 2; b++) begin : g_bus
        state_t          st_q, st_d;
        logic [OW-1:0]   own_q, own_d;
        logic [OW-1:0]   ptr_q, ptr_d;
        logic [OW-1:0]   pick, idx;
        logic [CW-1:0]   cnt_q, cnt_d;
        logic [HW-1:0]   hold_q, hold_d;
        logic            found;
        logic            preempt;
        logic [NREQ-1:0] elig, other, own_oh, sw_d, gnt_d;

        // A requester still switched onto the other bus is masked here.
        assign other  = (b == 0) ? sw_en_b : sw_en_a;
        assign elig   = req & ((b == 0) ? ~bus_sel : bus_sel)
                      & {NREQ{pwr_good}} & ~other;
        assign own_oh = {{(NREQ-1){1'b0}}, 1'b1} << own_q;
        assign preempt = (MAX_HOLD != 0) && (hold_q == HOLD_MAX)
                       && |(elig & ~own_oh);

        always_ff @(posedge clk) begin
            if (rst) begin
                st_q   <= IDLE;
                own_q  <= '0;
                ptr_q  <= OW'(NREQ - 1);
                cnt_q  <= '0;
                hold_q <= '0;
            end else begin
                st_q   <= st_d;
                own_q  <= own_d;
                ptr_q  <= ptr_d;
                cnt_q  <= cnt_d;
                hold_q <= hold_d;
            end
        end

        always_comb begin
            st_d   = st_q;
            own_d  = own_q;
            ptr_d  = ptr_q;
            cnt_d  = cnt_q;
            hold_d = hold_q;
            pick   = ptr_q;
            idx    = '0;
            found  = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                idx = OW'((int'(ptr_q) + k) % NREQ);
                if (!found && elig[idx]) begin
                    found = 1'b1;
                    pick  = idx;
                end
            end
            unique case (st_q)
                IDLE: begin
                    if (found) begin
                        st_d  = CONNECT;
                        own_d = pick;
                        ptr_d = pick;
                        cnt_d = '0;
                    end
                end
                CONNECT: begin
                    if (!elig[own_q]) begin
                        st_d  = BREAK;
                        cnt_d = '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        st_d   = OWNED;
                        hold_d = HOLD_INIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                OWNED: begin
                    if (!elig[own_q] || preempt) begin
                        st_d  = BREAK;
                        cnt_d = '0;
                    end else if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (cnt_q == BBM_LAST) begin
                        st_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
            sw_d  = '0;
            gnt_d = '0;
            if (st_d == CONNECT || st_d == OWNED) begin
                sw_d[own_d] = 1'b1;
            end
            if (st_d == OWNED) begin
                gnt_d[own_d] = 1'b1;
            end
        end

        assign sw_nx[b]  = sw_d;
        assign gnt_nx[b] = gnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_en_a <= '0;
            sw_en_b <= '0;
            gnt     <= '0;
        end else begin
            sw_en_a <= sw_nx[0];
            sw_en_b <= sw_nx[1];
            gnt     <= gnt_nx[0] | gnt_nx[1];
        end
    end

endmodule

// File: tb/tb_sky130_fd_io__amux_arbiter.sv
// Directed bench for the analog mux bus arbiter.
// NREQ=4, SETTLE=4, BBM=2, MAX_HOLD=8.
module tb_sky130_fd_io__amux_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pwr_good = 1'b1;
    logic [3:0] req = 4'b0;
    logic [3:0] bus_sel = 4'b0;
    logic [3:0] sw_en_a, sw_en_b, gnt;

    int checks = 0;
    int failures = 0;

    sky130_fd_io__amux_arbiter #(
        .NREQ(4),
        .SETTLE_CYCLES(4),
        .BBM_CYCLES(2),
        .MAX_HOLD(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pwr_good(pwr_good),
        .req(req),
        .bus_sel(bus_sel),
        .sw_en_a(sw_en_a),
        .sw_en_b(sw_en_b),
        .gnt(gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input string tag, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] g);
        chk({tag, "_a"}, 16'(sw_en_a), 16'(a));
        chk({tag, "_b"}, 16'(sw_en_b), 16'(b));
        chk({tag, "_g"}, 16'(gnt), 16'(g));
    endtask

    always @(negedge clk) begin
        chk("inv_ab", 16'(sw_en_a & sw_en_b), 16'd0);
        chk("inv_1a", 16'($countones(sw_en_a) <= 1), 16'd1);
        chk("inv_1b", 16'($countones(sw_en_b) <= 1), 16'd1);
        chk("inv_gnt", 16'(gnt & ~(sw_en_a | sw_en_b)), 16'd0);
    end

    initial begin
        tick(2);
        exp_out("rst", 4'h0, 4'h0, 4'h0);

        // single requester, settle timing
        rst = 1'b0;
        req = 4'b0001;
        tick;
        exp_out("t1_e1", 4'h1, 4'h0, 4'h0);
        tick(3);
        exp_out("t1_e4", 4'h1, 4'h0, 4'h0);
        tick;
        exp_out("t1_gnt", 4'h1, 4'h0, 4'h1);
        req = 4'b0000;
        tick;
        exp_out("t1_rel", 4'h0, 4'h0, 4'h0);
        tick(2);
        exp_out("t1_bbm", 4'h0, 4'h0, 4'h0);

        // contention, release, break-before-make
        req = 4'b0110;
        tick;
        exp_out("t2_pick", 4'h2, 4'h0, 4'h0);
        tick(4);
        exp_out("t2_gnt", 4'h2, 4'h0, 4'h2);
        req = 4'b0100;
        tick;
        exp_out("t2_rel", 4'h0, 4'h0, 4'h0);
        tick;
        exp_out("t2_bbm1", 4'h0, 4'h0, 4'h0);
        tick;
        exp_out("t2_bbm2", 4'h0, 4'h0, 4'h0);
        tick;
        exp_out("t2_next", 4'h4, 4'h0, 4'h0);
        tick(4);
        exp_out("t2_gnt2", 4'h4, 4'h0, 4'h4);

        // move requester 2 from bus A to bus B
        bus_sel = 4'b0100;
        tick;
        exp_out("t4_open", 4'h0, 4'h0, 4'h0);
        tick;
        exp_out("t4_b", 4'h0, 4'h4, 4'h0);
        tick(3);
        exp_out("t4_settle", 4'h0, 4'h4, 4'h0);
        tick;
        exp_out("t4_gnt", 4'h0, 4'h4, 4'h4);

        // both buses owned, then power-good drop
        req = 4'b0101;
        tick;
        exp_out("t5_a", 4'h1, 4'h4, 4'h4);
        tick(4);
        exp_out("t5_both", 4'h1, 4'h4, 4'h5);
        pwr_good = 1'b0;
        tick;
        exp_out("t5_pg", 4'h0, 4'h0, 4'h0);
        tick(5);
        exp_out("t5_pg_hold", 4'h0, 4'h0, 4'h0);
        pwr_good = 1'b1;
        tick;
        exp_out("t5_re", 4'h1, 4'h4, 4'h0);
        tick(3);
        exp_out("t5_re3", 4'h1, 4'h4, 4'h0);
        tick;
        exp_out("t5_regnt", 4'h1, 4'h4, 4'h5);
        req = 4'b0000;
        bus_sel = 4'b0000;
        tick(4);
        exp_out("t5_idle", 4'h0, 4'h0, 4'h0);

        // reset during CONNECT resets the pointer
        req = 4'b0010;
        tick;
        exp_out("t6_conn", 4'h2, 4'h0, 4'h0);
        tick;
        rst = 1'b1;
        tick;
        exp_out("t6_rst", 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        req = 4'b0011;
        tick;
        exp_out("t6_ptr", 4'h1, 4'h0, 4'h0);

        // max-hold preemption and alternation
        tick(4);
        exp_out("t3_gnt0", 4'h1, 4'h0, 4'h1);
        tick(7);
        exp_out("t3_hold0", 4'h1, 4'h0, 4'h1);
        tick;
        exp_out("t3_pre0", 4'h0, 4'h0, 4'h0);
        tick(2);
        exp_out("t3_bbm0", 4'h0, 4'h0, 4'h0);
        tick;
        exp_out("t3_sw1", 4'h2, 4'h0, 4'h0);
        tick(4);
        exp_out("t3_gnt1", 4'h2, 4'h0, 4'h2);
        tick(7);
        exp_out("t3_hold1", 4'h2, 4'h0, 4'h2);
        tick;
        exp_out("t3_pre1", 4'h0, 4'h0, 4'h0);

        // reset during BREAK skips the remaining dead time
        rst = 1'b1;
        tick;
        exp_out("t6_rstbrk", 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        tick;
        exp_out("t6_after", 4'h1, 4'h0, 4'h0);

        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
